serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_pkg.sv | 27 ++
 rtl/piso_shift.sv | 30 +++
 rtl/serial_word_tx.sv | 166 ++++++++++++++++
 tb/tb_serial_word_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter: FSM states, default
// geometry and the counter-width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 1;

    // ceil(log2(n)), never less than 1 so a counter always has at least one bit
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 <<< w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Loadable right-shift register; bit 0 is presented on lsb.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] sr_r;

    // Shift register: load has priority over shift
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r <= {WIDTH{1'b0}};
        end else if (load) begin
            sr_r <= din;
        end else if (shift) begin
            sr_r <= {1'b0, sr_r[WIDTH-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign lsb = sr_r[0];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with a one-entry holding buffer,
// a one-cycle sync strobe ahead of each word and a fixed idle gap after it.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             frame_reset,
    output logic             busy,
    output logic             done
);

    localparam int BW = clog2(WIDTH);
    localparam int GW = clog2(GAP);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    tx_state_t        state_r, state_s;
    logic [WIDTH-1:0] buf_r;
    logic             buf_full_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [GW-1:0]    gap_cnt_r;
    logic             accept_s, avail_s, load_sr_s, shift_s, sr_lsb_s;
    logic [WIDTH-1:0] word_s;
    logic             ser_next_s, frame_next_s, busy_next_s, done_next_s;
    logic             ser_out_r, frame_reset_r, busy_r, done_r;

    assign load_ready = ~buf_full_r & ~reset;
    assign accept_s   = load_valid & load_ready;
    // A word arriving while the shifter is free bypasses the buffer.
    assign avail_s    = buf_full_r | accept_s;
    assign word_s     = buf_full_r ? buf_r : data_in;
    assign shift_s    = (state_s == ST_SHIFT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic and shifter load decision
    always_comb begin
        state_s   = state_r;
        load_sr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (avail_s) begin
                    state_s   = ST_SYNC;
                    load_sr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != GAP_LAST) begin
                    state_s = ST_GAP;
                end else if (avail_s) begin
                    state_s   = ST_SYNC;
                    load_sr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the cycle being entered; registered below
    always_comb begin
        ser_next_s   = 1'b0;
        frame_next_s = (state_s == ST_SYNC);
        busy_next_s  = (state_s != ST_IDLE);
        done_next_s  = (state_r == ST_SHIFT) && (state_s == ST_GAP);
        if (state_s == ST_SHIFT) begin
            ser_next_s = sr_lsb_s;
        end else begin
            ser_next_s = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ser_out_r     <= 1'b0;
            frame_reset_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            ser_out_r     <= ser_next_s;
            frame_reset_r <= frame_next_s;
            busy_r        <= busy_next_s;
            done_r        <= done_next_s;
        end
    end

    // Holding buffer: filled only when the word cannot go straight to the shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full_r <= 1'b0;
            buf_r      <= {WIDTH{1'b0}};
        end else if (load_sr_s && buf_full_r) begin
            buf_full_r <= 1'b0;
            buf_r      <= buf_r;
        end else if (accept_s && !load_sr_s) begin
            buf_full_r <= 1'b1;
            buf_r      <= data_in;
        end else begin
            buf_full_r <= buf_full_r;
            buf_r      <= buf_r;
        end
    end

    // Bit and gap counters restart at zero on every entry to their state
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= {BW{1'b0}};
            gap_cnt_r <= {GW{1'b0}};
        end else begin
            if ((state_r == ST_SHIFT) && (state_s == ST_SHIFT)) begin
                bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end else begin
                bit_cnt_r <= {BW{1'b0}};
            end
            if ((state_r == ST_GAP) && (state_s == ST_GAP)) begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
        end
    end

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load_sr_s),
        .shift (shift_s),
        .din   (word_s),
        .lsb   (sr_lsb_s)
    );

    assign ser_out     = ser_out_r;
    assign frame_reset = frame_reset_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx (WIDTH=8, GAP=1) including a serial
// two's-complement consumer restarted by frame_reset.
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready, ser_out, frame_reset, busy, done;
    int         errors = 0;
    int         checks = 0;
    logic       seen_r = 1'b0;
    logic       conv_s;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(8), .GAP(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .ser_out     (ser_out),
        .frame_reset (frame_reset),
        .busy        (busy),
        .done        (done)
    );

    // Downstream converter: pass bits up to and including the first 1, invert afterwards
    always @(posedge clk) begin
        if (frame_reset) seen_r <= 1'b0;
        else if (ser_out) seen_r <= 1'b1;
    end
    assign conv_s = ser_out ^ seen_r;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Sends one word from idle; returns serial bits, converter bits and
    // {frame at c+1, done at c+10, idle at c+11}
    task automatic send_word(input logic [7:0] d, output logic [7:0] bits,
                             output logic [7:0] cbits, output logic [2:0] st);
        bits = 8'h00; cbits = 8'h00; st = 3'b000;
        step(); data_in = d; load_valid = 1'b1; sample();
        step(); load_valid = 1'b0; data_in = 8'h00; sample();
        st[2] = frame_reset;
        for (int k = 0; k < 8; k++) begin
            step(); sample();
            bits[k] = ser_out;
            cbits[k] = conv_s;
        end
        step(); sample();
        st[1] = done;
        step(); sample();
        st[0] = ~busy & ~done;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; data_in = 8'h00;
        repeat (3) step();
        sample();
        checks++;
        if ({ser_out, frame_reset, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {ser_out, frame_reset, busy, done, load_ready});
        end
        step(); reset = 1'b0; sample();
        checks++;
        if ({load_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 10", {load_ready, busy});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] got;
        logic       early_done;
        step(); data_in = 8'h37; load_valid = 1'b1; sample();
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_handshake: load_ready=%b required 1", load_ready);
        end
        step(); load_valid = 1'b0; data_in = 8'h00; sample();
        checks++;
        if ({frame_reset, ser_out, busy} !== 3'b101) begin
            errors++;
            $display("FAIL single_sync: got %b required 101", {frame_reset, ser_out, busy});
        end
        got = 8'h00; early_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(); sample();
            got[k] = ser_out;
            early_done = early_done | done | frame_reset;
        end
        checks++;
        if ({early_done, got} !== {1'b0, 8'h37}) begin
            errors++;
            $display("FAIL single_bits: got %b/%h required 0/37", early_done, got);
        end
        step(); sample();
        checks++;
        if ({done, ser_out, busy} !== 3'b101) begin
            errors++;
            $display("FAIL single_gap: got %b required 101", {done, ser_out, busy});
        end
        step(); sample();
        checks++;
        if ({done, busy, load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL single_idle: got %b required 001", {done, busy, load_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        step(); data_in = 8'h01; load_valid = 1'b1; sample();
        step(); data_in = 8'hFF; load_valid = 1'b1; sample();
        checks++;
        if ({frame_reset, load_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_second_accept: got %b required 11", {frame_reset, load_ready});
        end
        for (int t = 2; t <= 20; t++) begin
            step();
            if (t == 2) begin
                load_valid = 1'b0; data_in = 8'h00;
            end
            sample();
            exp_v = {(t == 2) || (t >= 12 && t <= 19), t == 11, t == 10 || t == 20, t >= 11};
            checks++;
            if ({ser_out, frame_reset, done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL b2b_cycle_%0d: ser/frame/done/ready=%b required %b",
                         t, {ser_out, frame_reset, done, load_ready}, exp_v);
            end
        end
        step(); sample();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_hold_full();
        logic [7:0] w1, w2;
        w1 = 8'h00; w2 = 8'h00;
        step(); data_in = 8'h3C; load_valid = 1'b1; sample();
        step(); data_in = 8'hC3; sample();
        for (int t = 2; t <= 19; t++) begin
            step();
            if (t <= 10) data_in = 8'(t * 53 + 7);
            else begin
                load_valid = 1'b0; data_in = 8'h00;
            end
            sample();
            if (t <= 9) w1[t-2] = ser_out;
            if (t >= 12) w2[t-12] = ser_out;
            if (t == 10) begin
                checks++;
                if (load_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_ready_low: load_ready=%b required 0", load_ready);
                end
            end
        end
        checks++;
        if (w1 !== 8'h3C) begin
            errors++;
            $display("FAIL hold_first_word: got %h required 3c", w1);
        end
        checks++;
        if (w2 !== 8'hC3) begin
            errors++;
            $display("FAIL hold_second_word: got %h required c3", w2);
        end
        repeat (2) step();
    endtask

    task automatic test_mid_reset();
        logic       flag;
        logic [7:0] bits, cbits;
        logic [2:0] st;
        step(); data_in = 8'hA5; load_valid = 1'b1; sample();
        step(); load_valid = 1'b0; data_in = 8'h00; sample();
        for (int t = 2; t <= 4; t++) begin
            step(); sample();
        end
        step(); reset = 1'b1; sample();
        checks++;
        if ({busy, load_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_during: busy/ready=%b required 10", {busy, load_ready});
        end
        step(); reset = 1'b0; sample();
        checks++;
        if ({ser_out, busy, done, frame_reset, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL midreset_after: got %b required 00001",
                     {ser_out, busy, done, frame_reset, load_ready});
        end
        flag = 1'b0;
        for (int t = 0; t < 6; t++) begin
            step(); sample();
            flag = flag | done | busy | ser_out;
        end
        checks++;
        if (flag !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: activity=%b required 0", flag);
        end
        send_word(8'h5A, bits, cbits, st);
        checks++;
        if ({st, bits} !== {3'b111, 8'h5A}) begin
            errors++;
            $display("FAIL midreset_next_word: got %b/%h required 111/5a", st, bits);
        end
    endtask

    task automatic test_twos_complement();
        logic [7:0] bits, cbits;
        logic [2:0] st;
        for (int n = 0; n < 2; n++) begin
            send_word(8'h14, bits, cbits, st);
            checks++;
            if ({st, bits, cbits} !== {3'b111, 8'h14, 8'hEC}) begin
                errors++;
                $display("FAIL twos_word_%0d: status/ser/conv=%b/%h/%h required 111/14/ec",
                         n, st, bits, cbits);
            end
        end
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; data_in = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold_full();
        test_mid_reset();
        test_twos_complement();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
